// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the external instruction-fetch responder.
// Optional feature macro: FETCH_TIMEOUT_EN (per-byte acknowledge timeout).
package imem_fetch_pkg;

    // Fetch sequencer states; encodings are fixed so debug taps stay stable.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_READ = 2'd1,
        FETCH_NEXT = 2'd2,
        FETCH_DONE = 2'd3
    } fetch_state_e;

    // Word returned when the external memory never acknowledges (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Selects one of the four byte lanes of a 32-bit word.
    typedef logic [1:0] byte_lane_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Four-lane byte buffer that assembles a little-endian 32-bit instruction.
// Lane 0 holds the byte from address offset 0 and lands in word[7:0].
// Optional feature macro: none (shared by both FETCH_TIMEOUT_EN builds).
module imem_word_assembler
    import imem_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        wr_en,
    input  byte_lane_t  lane,
    input  logic [7:0]  wr_data,
    output logic [31:0] word
);

    logic [3:0][7:0] buf_q;
    logic [3:0][7:0] buf_d;

    // Clear wins over a write so an aborted word never leaks into the next one.
    always_comb begin
        buf_d = buf_q;
        if (clear) begin
            buf_d = '0;
        end else if (wr_en) begin
            buf_d[lane] = wr_data;
        end
    end

    // Byte buffer storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign word = buf_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Responder for the core's external instruction-fetch port. When pc[31] is
// set it reads the addressed word one byte at a time from a byte-wide memory,
// then presents it on instr with a one-cycle valid pulse and a delayed
// valid_reg. The last completed word is remembered so a held pc is not
// refetched.
// Optional feature macro: FETCH_TIMEOUT_EN -- a byte that is not acknowledged
// within TIMEOUT cycles completes the fetch with a NOP and sets the sticky
// fetch_err flag. Without the macro READ waits indefinitely and fetch_err is 0.
//
// Handshake: mem_rd is held high for the whole READ state; the byte on
// mem_rdata is taken on the cycle mem_ack is high and mem_rd drops on that same
// edge. mem_ack outside READ is ignored. A reset withdraws mem_rd at once.
//
// dbg_status = {suspend, state}; state encodings come from fetch_state_e.
module imem_fetch_responder
    import imem_fetch_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       pc,
    input  logic              suspend,
    output logic [31:0]       instr,
    output logic              valid,
    output logic              valid_reg,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              fetch_err,
    output logic [2:0]        dbg_status
);

    localparam logic [1:0] ST_IDLE = 2'(FETCH_IDLE);
    localparam logic [1:0] ST_READ = 2'(FETCH_READ);
    localparam logic [1:0] ST_NEXT = 2'(FETCH_NEXT);
    localparam logic [1:0] ST_DONE = 2'(FETCH_DONE);

    logic [1:0]  state_q,      state_d;
    logic [31:0] req_pc_q,     req_pc_d;
    byte_lane_t  byte_idx_q,   byte_idx_d;
    logic [31:0] served_pc_q,  served_pc_d;
    logic        served_vld_q, served_vld_d;
    logic [31:0] instr_q,      instr_d;
    logic        valid_reg_q,  valid_reg_d;
    logic        fetch_err_q,  fetch_err_d;

    logic        req_needed;
    logic        pc_moved;
    logic        buf_clear;
    logic        buf_wr_en;
    logic [31:0] buf_word;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // A fresh fetch is required for an external pc that is not the word held.
    assign req_needed = pc[31] && (!served_vld_q || (pc != served_pc_q));

    // The core has left the address currently being assembled.
    assign pc_moved = (pc != req_pc_q) || !pc[31];

    // Sequencer next-state and register updates.
    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        byte_idx_d   = byte_idx_q;
        served_pc_d  = served_pc_q;
        served_vld_d = served_vld_q;
        instr_d      = instr_q;
        fetch_err_d  = fetch_err_q;
        buf_clear    = 1'b0;
        buf_wr_en    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_needed) begin
                    req_pc_d   = pc;
                    byte_idx_d = '0;
                    state_d    = ST_READ;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
            end

            ST_READ: begin
                if (mem_ack) begin
                    buf_wr_en = 1'b1;
                    state_d   = ST_NEXT;
`ifdef FETCH_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Give the core a harmless NOP and force a refetch later.
                    buf_clear    = 1'b1;
                    instr_d      = NOP_INSTR;
                    served_vld_d = 1'b0;
                    fetch_err_d  = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end

            ST_NEXT: begin
                if (pc_moved) begin
                    // Partial word belongs to an address the core abandoned.
                    buf_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (byte_idx_q == 2'd3) begin
                    instr_d      = buf_word;
                    served_pc_d  = req_pc_q;
                    served_vld_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    state_d    = ST_READ;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
            end

            default: begin
                // DONE: word is presented this cycle; start clean next time.
                buf_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // valid_reg is valid from the previous cycle, including back-to-back words.
    always_comb begin
        valid_reg_d = (state_q == ST_DONE);
    end

    // Sequencer and output state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_pc_q     <= '0;
            byte_idx_q   <= '0;
            served_pc_q  <= '0;
            served_vld_q <= 1'b0;
            instr_q      <= '0;
            valid_reg_q  <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            byte_idx_q   <= byte_idx_d;
            served_pc_q  <= served_pc_d;
            served_vld_q <= served_vld_d;
            instr_q      <= instr_d;
            valid_reg_q  <= valid_reg_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Per-byte acknowledge wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    imem_word_assembler u_assembler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (buf_clear),
        .wr_en   (buf_wr_en),
        .lane    (byte_idx_q),
        .wr_data (mem_rdata),
        .word    (buf_word)
    );

    assign instr      = instr_q;
    assign valid      = (state_q == ST_DONE);
    assign valid_reg  = valid_reg_q;
    assign mem_rd     = (state_q == ST_READ);
    assign mem_addr   = (state_q == ST_READ) ? {req_pc_q[ADDR_W-1:2], byte_idx_q} : '0;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = fetch_err_q;
`else
    assign fetch_err  = 1'b0;
`endif
    assign dbg_status = {suspend, state_q};

endmodule
